// File: rtl/calc_engine_p.sv
// calc_engine_p: keypad-driven calculator engine with chained add/subtract/multiply,
// sticky overflow and an optional shift-add multiplier.
module calc_engine_p #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MUL_ITER = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_key,
  input  logic [4:0]       keycode,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             overflow,
  output logic [2:0]       op_pending
);

  localparam int unsigned Digits = WIDTH / 4;
  localparam int unsigned DcW    = $clog2(Digits + 1);
  localparam int unsigned ItW    = $clog2(WIDTH);
  localparam logic [DcW-1:0] DigitsC = DcW'(Digits);
  localparam logic [ItW-1:0] IterLast = ItW'(WIDTH - 1);

  // Op encodings match the low bits of the corresponding command keycodes.
  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpPlus  = 3'd2,
    OpMul   = 3'd3,
    OpMinus = 3'd5
  } op_e;

  typedef enum logic [0:0] {StIdle, StMult} state_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  op_e                op_after_q, op_after_d;  // op to install when the multiply finishes
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               fresh_q, fresh_d;
  logic               show_y_q, show_y_d;
  logic [DcW-1:0]     count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [ItW-1:0]     iter_q, iter_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_comb;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   res;
  logic               res_ovf;
  logic               start_mult;
  logic               is_clear;
  logic               is_eval;
  op_e                new_op;

  // Next-state logic: key decode, arithmetic and multiplier sequencing.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_after_d = op_after_q;
    x_d        = x_q;
    y_d        = y_q;
    fresh_d    = fresh_q;
    show_y_d   = show_y_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    mcand_d    = mcand_q;
    mplr_d     = mplr_q;
    prod_d     = prod_q;
    iter_d     = iter_q;

    sum        = {1'b0, y_q} + {1'b0, x_q};
    prod_comb  = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, x_q};
    prod_step  = prod_q + (mplr_q[0] ? mcand_q : '0);
    res        = x_q;
    res_ovf    = 1'b0;
    start_mult = 1'b0;

    // Result of applying the pending op to y and x.
    unique case (op_q)
      OpPlus: begin
        res     = sum[WIDTH-1:0];
        res_ovf = sum[WIDTH];
      end
      OpMinus: begin
        res     = y_q - x_q;
        res_ovf = (x_q > y_q);
      end
      OpMul: begin
        if (MUL_ITER == 0) begin
          res     = prod_comb[WIDTH-1:0];
          res_ovf = |prod_comb[2*WIDTH-1:WIDTH];
        end else begin
          start_mult = 1'b1;
        end
      end
      default: res = x_q;
    endcase

    is_clear = new_key && (keycode == 5'b0_0001);
    is_eval  = new_key && !keycode[4] &&
               ((keycode[3:0] == 4'h2) || (keycode[3:0] == 4'h3) ||
                (keycode[3:0] == 4'h4) || (keycode[3:0] == 4'h5));
    new_op   = (keycode[3:0] == 4'h4) ? OpNone : op_e'(keycode[2:0]);

    if (state_q == StIdle) begin
      if (new_key && keycode[4]) begin
        if (fresh_q) begin
          x_d     = {{(WIDTH-4){1'b0}}, keycode[3:0]};
          count_d = DcW'(1);
          fresh_d = 1'b0;
        end else if (count_q < DigitsC) begin
          x_d     = {x_q[WIDTH-5:0], keycode[3:0]};
          count_d = count_q + 1'b1;
        end
        show_y_d = 1'b0;
      end else if (is_eval) begin
        if (start_mult) begin
          state_d    = StMult;
          op_after_d = new_op;
          mcand_d    = {{WIDTH{1'b0}}, y_q};
          mplr_d     = x_q;
          prod_d     = '0;
          iter_d     = IterLast;
        end else begin
          y_d      = res;
          ovf_d    = ovf_q | res_ovf;
          op_d     = new_op;
          fresh_d  = 1'b1;
          show_y_d = 1'b1;
        end
      end
    end else begin
      // One shift-add step per cycle; results commit on the last step.
      prod_d  = prod_step;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      iter_d  = iter_q - 1'b1;
      if (iter_q == '0) begin
        state_d  = StIdle;
        y_d      = prod_step[WIDTH-1:0];
        ovf_d    = ovf_q | (|prod_step[2*WIDTH-1:WIDTH]);
        op_d     = op_after_q;
        fresh_d  = 1'b1;
        show_y_d = 1'b1;
      end
    end

    // CLEAR wins in any state and matches reset.
    if (is_clear) begin
      state_d    = StIdle;
      op_d       = OpNone;
      op_after_d = OpNone;
      x_d        = '0;
      y_d        = '0;
      fresh_d    = 1'b1;
      show_y_d   = 1'b0;
      count_d    = '0;
      ovf_d      = 1'b0;
      mcand_d    = '0;
      mplr_d     = '0;
      prod_d     = '0;
      iter_d     = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpNone;
      op_after_q <= OpNone;
      x_q        <= '0;
      y_q        <= '0;
      fresh_q    <= 1'b1;
      show_y_q   <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      prod_q     <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_after_q <= op_after_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fresh_q    <= fresh_d;
      show_y_q   <= show_y_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mcand_q    <= mcand_d;
      mplr_q     <= mplr_d;
      prod_q     <= prod_d;
      iter_q     <= iter_d;
    end
  end

  // Output mapping.
  always_comb begin
    value      = show_y_q ? y_q : x_q;
    busy       = (state_q == StMult);
    overflow   = ovf_q;
    op_pending = op_q;
  end

endmodule
